// File: rtl/pc_sequencer_pkg.sv
// rtl/pc_sequencer_pkg.sv - shared encodings and counter helpers for the fetch PC sequencer
package pc_sequencer_pkg;

   localparam logic [31:0] PC_RESET_DEFAULT  = 32'h00400000;
   localparam int          BTB_IDX_W_DEFAULT = 4;

   localparam logic [1:0] PCS_NONE   = 2'b00;
   localparam logic [1:0] PCS_BRANCH = 2'b01;
   localparam logic [1:0] PCS_JAL    = 2'b10;
   localparam logic [1:0] PCS_JALR   = 2'b11;

   localparam logic [1:0] PCSRC_NT    = 2'b00;
   localparam logic [1:0] PCSRC_PCREL = 2'b01;
   localparam logic [1:0] PCSRC_JALR  = 2'b11;

   typedef enum logic [1:0] {
      CTR_SNT = 2'b00,
      CTR_WNT = 2'b01,
      CTR_WT  = 2'b10,
      CTR_ST  = 2'b11
   } ctr_t;

   // Saturating 2-bit counter step; both extremes are sticky.
   function automatic ctr_t ctr_next(input ctr_t c, input logic taken);
      ctr_t n;
      n = c;
      if (taken && c != CTR_ST)
         n = ctr_t'(c + 2'd1);
      else if (!taken && c != CTR_SNT)
         n = ctr_t'(c - 2'd1);
      return n;
   endfunction

endpackage

// File: rtl/pc_sequencer_branch_target_buffer.sv
// rtl/pc_sequencer_branch_target_buffer.sv - direct-mapped BTB, async fetch read, sync update write
module branch_target_buffer
   import pc_sequencer_pkg::*;
#(
   parameter int IDX_W = BTB_IDX_W_DEFAULT
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [31:2] rd_pc,
   output logic        rd_hit,
   output ctr_t        rd_ctr,
   output logic [31:2] rd_target,
   input  logic [31:2] up_pc,
   output logic        up_hit,
   output ctr_t        up_ctr,
   input  logic        ctr_we,
   input  ctr_t        ctr_wdata,
   input  logic        alloc_we,
   input  logic [31:2] alloc_target,
   input  ctr_t        alloc_ctr
);

   localparam int N     = 1 << IDX_W;
   localparam int TAG_W = 32 - IDX_W - 2;

   logic              valid_q [N];
   logic [TAG_W-1:0]  tag_q   [N];
   logic [31:2]       tgt_q   [N];
   ctr_t              ctr_q   [N];

   logic [IDX_W-1:0]  rd_idx, up_idx;
   logic [TAG_W-1:0]  rd_tag, up_tag;

   assign rd_idx = rd_pc[IDX_W+1:2];
   assign rd_tag = rd_pc[31:IDX_W+2];
   assign up_idx = up_pc[IDX_W+1:2];
   assign up_tag = up_pc[31:IDX_W+2];

   // Reads see the registered array only, so a same-cycle write is not forwarded.
   assign rd_hit    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
   assign rd_ctr    = ctr_q[rd_idx];
   assign rd_target = tgt_q[rd_idx];
   assign up_hit    = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
   assign up_ctr    = ctr_q[up_idx];

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         for (int i = 0; i < N; i++) begin
            valid_q[i] <= 1'b0;
            tag_q[i]   <= '0;
            tgt_q[i]   <= '0;
            ctr_q[i]   <= CTR_WNT;
         end
      end else if (alloc_we) begin
         valid_q[up_idx] <= 1'b1;
         tag_q[up_idx]   <= up_tag;
         tgt_q[up_idx]   <= alloc_target;
         ctr_q[up_idx]   <= alloc_ctr;
      end else if (ctr_we) begin
         ctr_q[up_idx]   <= ctr_wdata;
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch PC register, next-PC select, mispredict detect and BTB training
module pc_sequencer
   import pc_sequencer_pkg::*;
#(
   parameter logic [31:0] PC_RESET  = PC_RESET_DEFAULT,
   parameter int          BTB_IDX_W = BTB_IDX_W_DEFAULT
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        Stall_F,
   output logic [31:0] PC_F,
   output logic        PredTaken_F,
   input  logic        Valid_E,
   input  logic [1:0]  PCS_E,
   input  logic [1:0]  PCSrc_E,
   input  logic [31:0] PC_E,
   input  logic        PredTaken_E,
   input  logic [31:0] BranchTgt_E,
   input  logic [31:0] JalrTgt_E,
   output logic        Flush,
   output logic        BranchMispredicted
);

   logic [31:0] pc_q;
   logic [31:0] next_pc;
   logic [31:0] redirect_pc;
   logic        f_hit;
   ctr_t        f_ctr;
   logic [31:2] f_target;
   logic        e_hit;
   ctr_t        e_ctr;
   logic        actual_taken;
   logic        mispredict;
   logic        train;
   logic        ctr_we;
   logic        alloc_we;
   ctr_t        alloc_ctr;
   ctr_t        ctr_wdata;
   logic        unused_tgt_bits;

   assign unused_tgt_bits = ^BranchTgt_E[1:0];

   branch_target_buffer #(
      .IDX_W (BTB_IDX_W)
   ) u_btb (
      .CLK          (CLK),
      .RESET        (RESET),
      .rd_pc        (pc_q[31:2]),
      .rd_hit       (f_hit),
      .rd_ctr       (f_ctr),
      .rd_target    (f_target),
      .up_pc        (PC_E[31:2]),
      .up_hit       (e_hit),
      .up_ctr       (e_ctr),
      .ctr_we       (ctr_we),
      .ctr_wdata    (ctr_wdata),
      .alloc_we     (alloc_we),
      .alloc_target (BranchTgt_E[31:2]),
      .alloc_ctr    (alloc_ctr)
   );

   assign PC_F        = pc_q;
   assign PredTaken_F = f_hit && f_ctr[1];

   // jalr is never predicted, so it always counts as a mispredict.
   assign actual_taken = (PCSrc_E != PCSRC_NT);
   assign mispredict   = RESET && Valid_E && (PCS_E != PCS_NONE) &&
                         ((PCS_E == PCS_JALR) || (actual_taken != PredTaken_E));

   assign Flush              = mispredict;
   assign BranchMispredicted = mispredict;

   always_comb begin
      redirect_pc = PC_E + 32'd4;
      case (PCSrc_E)
         PCSRC_PCREL: redirect_pc = BranchTgt_E;
         PCSRC_JALR:  redirect_pc = JalrTgt_E & 32'hFFFF_FFFE;
         default:     redirect_pc = PC_E + 32'd4;
      endcase
   end

   always_comb begin
      next_pc = pc_q + 32'd4;
      if (mispredict)
         next_pc = redirect_pc;
      else if (Stall_F)
         next_pc = pc_q;
      else if (PredTaken_F)
         next_pc = {f_target, 2'b00};
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET)
         pc_q <= PC_RESET;
      else
         pc_q <= next_pc;
   end

   assign train     = Valid_E && ((PCS_E == PCS_BRANCH) || (PCS_E == PCS_JAL));
   assign ctr_we    = train && e_hit;
   assign alloc_we  = train && !e_hit && actual_taken;
   assign alloc_ctr = (PCS_E == PCS_JAL) ? CTR_ST : CTR_WT;
   assign ctr_wdata = ctr_next(e_ctr, actual_taken);

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - scoreboard bench for pc_sequencer against a behavioural reference
module tb_pc_sequencer;

   localparam logic [31:0] RST_PC = 32'h00400000;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        Stall_F;
   logic [31:0] PC_F;
   logic        PredTaken_F;
   logic        Valid_E;
   logic [1:0]  PCS_E;
   logic [1:0]  PCSrc_E;
   logic [31:0] PC_E;
   logic        PredTaken_E;
   logic [31:0] BranchTgt_E;
   logic [31:0] JalrTgt_E;
   logic        Flush;
   logic        BranchMispredicted;

   int n_cmp = 0;
   int n_bad = 0;
   logic [31:0] exp_q[$];

   logic        m_v   [16];
   logic [25:0] m_tag [16];
   logic [31:0] m_tgt [16];
   logic [1:0]  m_ctr [16];
   logic [31:0] m_pc;

   pc_sequencer dut (
      .CLK                (CLK),
      .RESET              (RESET),
      .Stall_F            (Stall_F),
      .PC_F               (PC_F),
      .PredTaken_F        (PredTaken_F),
      .Valid_E            (Valid_E),
      .PCS_E              (PCS_E),
      .PCSrc_E            (PCSrc_E),
      .PC_E               (PC_E),
      .PredTaken_E        (PredTaken_E),
      .BranchTgt_E        (BranchTgt_E),
      .JalrTgt_E          (JalrTgt_E),
      .Flush              (Flush),
      .BranchMispredicted (BranchMispredicted)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic model_reset();
      m_pc = RST_PC;
      for (int i = 0; i < 16; i++) begin
         m_v[i]   = 1'b0;
         m_tag[i] = '0;
         m_tgt[i] = '0;
         m_ctr[i] = 2'b01;
      end
      exp_q.delete();
   endtask

   // One clock: drive E/stall inputs, check combinational outputs, push the expected PC, pop after the edge.
   task automatic cyc(input logic v, input logic [1:0] pcs, input logic [1:0] pcsrc,
                      input logic [31:0] pce, input logic pe, input logic [31:0] bt,
                      input logic [31:0] jt, input logic st);
      logic [3:0]  fi, ei;
      logic        pf, act, mis, hit_e;
      logic [31:0] rt, nxt;
      Valid_E = v; PCS_E = pcs; PCSrc_E = pcsrc; PC_E = pce;
      PredTaken_E = pe; BranchTgt_E = bt; JalrTgt_E = jt; Stall_F = st;
      #1;
      fi  = m_pc[5:2];
      pf  = m_v[fi] && (m_tag[fi] == m_pc[31:6]) && m_ctr[fi][1];
      act = (pcsrc != 2'b00);
      mis = v && (pcs != 2'b00) && ((pcs == 2'b11) || (act != pe));
      if (pcsrc == 2'b01)      rt = bt;
      else if (pcsrc == 2'b11) rt = {jt[31:1], 1'b0};
      else                     rt = pce + 32'd4;
      if (mis)     nxt = rt;
      else if (st) nxt = m_pc;
      else if (pf) nxt = m_tgt[fi];
      else         nxt = m_pc + 32'd4;
      check("flush", {31'd0, Flush}, {31'd0, mis});
      check("mispred", {31'd0, BranchMispredicted}, {31'd0, mis});
      check("pred_f", {31'd0, PredTaken_F}, {31'd0, pf});
      exp_q.push_back(nxt);
      ei    = pce[5:2];
      hit_e = m_v[ei] && (m_tag[ei] == pce[31:6]);
      if (v && (pcs == 2'b01 || pcs == 2'b10)) begin
         if (hit_e) begin
            if (act && m_ctr[ei] != 2'b11)       m_ctr[ei] = m_ctr[ei] + 2'd1;
            else if (!act && m_ctr[ei] != 2'b00) m_ctr[ei] = m_ctr[ei] - 2'd1;
         end else if (act) begin
            m_v[ei]   = 1'b1;
            m_tag[ei] = pce[31:6];
            m_tgt[ei] = bt;
            m_ctr[ei] = (pcs == 2'b01) ? 2'b10 : 2'b11;
         end
      end
      m_pc = nxt;
      @(posedge CLK);
      #1;
      check("pc_f", PC_F, exp_q.pop_front());
   endtask

   task automatic idle(input logic st);
      cyc(1'b0, 2'b00, 2'b00, 32'h0, 1'b0, 32'h0, 32'h0, st);
   endtask

   task automatic jalr(input logic [31:0] tgt);
      cyc(1'b1, 2'b11, 2'b11, 32'h00400200, 1'b0, 32'h0, tgt, 1'b0);
   endtask

   task automatic beq(input logic [31:0] pc, input logic taken, input logic pe, input logic [31:0] tgt);
      cyc(1'b1, 2'b01, taken ? 2'b01 : 2'b00, pc, pe, tgt, 32'h0, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      RESET = 1'b0; Stall_F = 1'b0; Valid_E = 1'b0; PCS_E = 2'b00; PCSrc_E = 2'b00;
      PC_E = '0; PredTaken_E = 1'b0; BranchTgt_E = '0; JalrTgt_E = '0;
      model_reset();
      repeat (2) @(posedge CLK);
      #1;
      check("rst_pc", PC_F, RST_PC);
      check("rst_flush", {31'd0, Flush}, 32'd0);
      check("rst_pred", {31'd0, PredTaken_F}, 32'd0);
      @(negedge CLK);
      RESET = 1'b1;
      #1;
      check("rel_pc", PC_F, RST_PC);

      idle(1'b0); check("t1_pc1", PC_F, 32'h00400004);
      idle(1'b0); check("t1_pc2", PC_F, 32'h00400008);

      beq(32'h00400010, 1'b1, 1'b0, 32'h00400040);
      check("t2_pc", PC_F, 32'h00400040);

      jalr(32'h00400010);
      check("t3_pred", {31'd0, PredTaken_F}, 32'd1);
      idle(1'b0); check("t3_pc", PC_F, 32'h00400040);
      beq(32'h00400010, 1'b1, 1'b1, 32'h00400040);

      jalr(32'h00400010);
      beq(32'h00400010, 1'b0, 1'b1, 32'h00400040);
      check("t4_pc", PC_F, 32'h00400014);
      beq(32'h00400010, 1'b0, 1'b1, 32'h00400040);
      jalr(32'h00400010);
      check("t4_pred", {31'd0, PredTaken_F}, 32'd0);
      idle(1'b0);

      jalr(32'h00400101);
      check("t5_pc", PC_F, 32'h00400100);
      jalr(32'h00400010);

      cyc(1'b1, 2'b10, 2'b01, 32'h00400060, 1'b0, 32'h00400090, 32'h0, 1'b0);
      jalr(32'h00400060);
      check("jal_pred", {31'd0, PredTaken_F}, 32'd1);
      idle(1'b0); check("jal_pc", PC_F, 32'h00400090);

      cyc(1'b1, 2'b01, 2'b01, 32'h00400020, 1'b0, 32'h00400080, 32'h0, 1'b1);
      check("t6_stall_redir", PC_F, 32'h00400080);
      idle(1'b1); check("t6_hold", PC_F, 32'h00400080);
      jalr(32'h00400030);
      beq(32'h00400030, 1'b1, 1'b0, 32'h00400050);
      check("t6_pc", PC_F, 32'h00400050);
      jalr(32'h00400030);
      check("t6_pred", {31'd0, PredTaken_F}, 32'd1);

      jalr(32'hFFFFFFFC);
      idle(1'b0); check("wrap_pc", PC_F, 32'h00000000);

      jalr(32'h00400010);
      Valid_E = 1'b1; PCS_E = 2'b11; PCSrc_E = 2'b11; JalrTgt_E = 32'h00400300;
      #2;
      RESET = 1'b0;
      #1;
      check("mid_rst_pc", PC_F, RST_PC);
      check("mid_rst_flush", {31'd0, Flush}, 32'd0);
      check("mid_rst_pred", {31'd0, PredTaken_F}, 32'd0);
      @(negedge CLK);
      RESET = 1'b1; Valid_E = 1'b0;
      model_reset();
      #1;
      check("post_rst_pc", PC_F, RST_PC);
      jalr(32'h00400030); check("post_rst_miss0", {31'd0, PredTaken_F}, 32'd0);
      jalr(32'h00400060); check("post_rst_miss1", {31'd0, PredTaken_F}, 32'd0);
      jalr(32'h00400010); check("post_rst_miss2", {31'd0, PredTaken_F}, 32'd0);
      idle(1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
